// File: rtl/mac_mon_pkg.sv
// mac_mon_pkg: shared definitions for the MAC RX statistics monitor.
// Holds the counter index map, frame-length bin boundaries and the
// statistics-vector field positions used by every file of the block.
package mac_mon_pkg;

    // Statistics vector layout
    localparam int STATS_VEC_W   = 29;
    localparam int STATS_OK_BIT  = 0;
    localparam int STATS_LEN_LSB = 5;
    localparam int STATS_LEN_MSB = 18;
    localparam int STATS_LEN_W   = STATS_LEN_MSB - STATS_LEN_LSB + 1;

    // Counter index map
    localparam int CNT_GOOD         = 0;
    localparam int CNT_BAD          = 1;
    localparam int CNT_STATS        = 2;
    localparam int CNT_BYTES        = 3;
    localparam int CNT_BIN_LE64     = 4;
    localparam int CNT_BIN_65_127   = 5;
    localparam int CNT_BIN_128_255  = 6;
    localparam int CNT_BIN_256_511  = 7;
    localparam int CNT_BIN_512_1023 = 8;
    localparam int CNT_BIN_1024_MAX = 9;
    localparam int CNT_BIN_OVER_MAX = 10;

    localparam int NUM_CNT_BASE = 4;
    localparam int NUM_CNT_HIST = 11;
    localparam int RD_SEL_W     = 4;

    // Upper bound (inclusive) of each length bin
    localparam int BIN_MAX_64   = 64;
    localparam int BIN_MAX_127  = 127;
    localparam int BIN_MAX_255  = 255;
    localparam int BIN_MAX_511  = 511;
    localparam int BIN_MAX_1023 = 1023;
    localparam int BIN_MAX_1518 = 1518;

    typedef logic [STATS_LEN_W-1:0] frame_len_t;

    typedef struct packed {
        logic       ok;
        frame_len_t len;
    } stats_fields_t;

    // Map a frame length to its histogram counter index
    function automatic int len_bin(input frame_len_t len);
        if (len <= frame_len_t'(BIN_MAX_64))   return CNT_BIN_LE64;
        if (len <= frame_len_t'(BIN_MAX_127))  return CNT_BIN_65_127;
        if (len <= frame_len_t'(BIN_MAX_255))  return CNT_BIN_128_255;
        if (len <= frame_len_t'(BIN_MAX_511))  return CNT_BIN_256_511;
        if (len <= frame_len_t'(BIN_MAX_1023)) return CNT_BIN_512_1023;
        if (len <= frame_len_t'(BIN_MAX_1518)) return CNT_BIN_1024_MAX;
        return CNT_BIN_OVER_MAX;
    endfunction

endpackage

// File: rtl/mac_rx_stats_mon_if.sv
// mac_rx_stats_mon_if: MAC RX event inputs plus the snapshot/readout bus.
// master = MAC/host side driving events and reads; slave = the monitor.
interface mac_rx_stats_mon_if #(
    parameter int CNT_W = 32
);
    import mac_mon_pkg::*;

    logic                   mon_en;
    logic                   rx_good_frame;
    logic                   rx_bad_frame;
    logic [STATS_VEC_W-1:0] rx_statistics_vector;
    logic                   rx_statistics_valid;
    logic                   snap_req;
    logic                   snap_done;
    logic [RD_SEL_W-1:0]    rd_sel;
    logic [CNT_W-1:0]       rd_data;

    modport master (
        output mon_en, rx_good_frame, rx_bad_frame,
        output rx_statistics_vector, rx_statistics_valid,
        output snap_req, rd_sel,
        input  snap_done, rd_data
    );

    modport slave (
        input  mon_en, rx_good_frame, rx_bad_frame,
        input  rx_statistics_vector, rx_statistics_valid,
        input  snap_req, rd_sel,
        output snap_done, rd_data
    );

endinterface

// File: rtl/mac_stat_cnt.sv
// mac_stat_cnt: one statistics counter. Adds inc_amt when inc_en is set,
// either saturating at all-ones or wrapping. clr zeroes the old value in the
// same cycle so a coincident increment still lands in the cleared counter.
module mac_stat_cnt #(
    parameter int CNT_W    = 32,
    parameter int SATURATE = 1
) (
    input  logic             clk156,
    input  logic             reset,
    input  logic             inc_en,
    input  logic [CNT_W-1:0] inc_amt,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    // Add with carry-out; clamp to all-ones on overflow when saturating
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if ((SATURATE != 0) && sum[CNT_W]) return '1;
        return sum[CNT_W-1:0];
    endfunction

    logic [CNT_W-1:0] base_p0;
    logic [CNT_W-1:0] next_p0;

    // Next value: optional clear first, then the increment on top of it
    always_comb begin
        base_p0 = clr ? '0 : cnt;
        next_p0 = inc_en ? sat_add(base_p0, inc_amt) : base_p0;
    end

    // Counter register
    always_ff @(posedge clk156) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= next_p0;
        end
    end

endmodule

// File: rtl/mac_rx_stats_mon.sv
// mac_rx_stats_mon: MAC RX statistics monitor. Live counters for good/bad
// frames, stats-vector events and good bytes; snap_req copies them into
// shadow registers that are read back through rd_sel/rd_data.
// Build option: define MAC_RX_STATS_LEN_HIST_EN to add the frame-length
// histogram counters 4..10; without it those indices read as 0.
module mac_rx_stats_mon
    import mac_mon_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int SATURATE    = 1,
    parameter int CLR_ON_SNAP = 0
) (
    input  logic              clk156,
    input  logic              reset,
    mac_rx_stats_mon_if.slave bus
);

`ifdef MAC_RX_STATS_LEN_HIST_EN
    localparam int NUM_CNT = NUM_CNT_HIST;
`else
    localparam int NUM_CNT = NUM_CNT_BASE;
`endif

    stats_fields_t      stats_p0;
    logic               good_stats_p0;
    logic               snap_p0;
    logic               clr_p0;
    logic [NUM_CNT-1:0] inc_en_p0;
    logic [CNT_W-1:0]   inc_amt_p0 [NUM_CNT];
    logic [CNT_W-1:0]   live_p0    [NUM_CNT];
    logic [CNT_W-1:0]   shadow_p1  [NUM_CNT];
    logic               vld_p1;
    logic [CNT_W-1:0]   rd_mux_p1;
    logic [CNT_W-1:0]   rd_data_p2;
    logic               unused_stat_bits;

    // ---- stage p0: event decode and live counters ----
    assign stats_p0.ok    = bus.rx_statistics_vector[STATS_OK_BIT];
    assign stats_p0.len   = bus.rx_statistics_vector[STATS_LEN_MSB:STATS_LEN_LSB];
    assign good_stats_p0  = bus.rx_statistics_valid & stats_p0.ok;
    assign snap_p0        = bus.snap_req & ~reset;
    assign clr_p0         = snap_p0 & (CLR_ON_SNAP != 0);
    assign unused_stat_bits = ^{bus.rx_statistics_vector[STATS_VEC_W-1:STATS_LEN_MSB+1],
                                bus.rx_statistics_vector[STATS_LEN_LSB-1:STATS_OK_BIT+1]};

    // Per-counter increment enable and amount, gated by mon_en
    always_comb begin
        inc_en_p0 = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            inc_amt_p0[i] = CNT_W'(1);
        end
        inc_en_p0[CNT_GOOD]   = bus.rx_good_frame;
        inc_en_p0[CNT_BAD]    = bus.rx_bad_frame;
        inc_en_p0[CNT_STATS]  = bus.rx_statistics_valid;
        inc_en_p0[CNT_BYTES]  = good_stats_p0;
        inc_amt_p0[CNT_BYTES] = CNT_W'(stats_p0.len);
`ifdef MAC_RX_STATS_LEN_HIST_EN
        for (int b = CNT_BIN_LE64; b < NUM_CNT; b++) begin
            if (len_bin(stats_p0.len) == b) inc_en_p0[b] = good_stats_p0;
        end
`endif
        for (int i = 0; i < NUM_CNT; i++) begin
            inc_en_p0[i] = inc_en_p0[i] & bus.mon_en;
        end
    end

    for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
        mac_stat_cnt #(
            .CNT_W    (CNT_W),
            .SATURATE (SATURATE)
        ) u_cnt (
            .clk156  (clk156),
            .reset   (reset),
            .inc_en  (inc_en_p0[g]),
            .inc_amt (inc_amt_p0[g]),
            .clr     (clr_p0),
            .cnt     (live_p0[g])
        );
    end

    // ---- stage p1: shadow snapshot and snap_done ----
    // Snapshot takes the live values as they were before this cycle's events
    always_ff @(posedge clk156) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            for (int i = 0; i < NUM_CNT; i++) begin
                shadow_p1[i] <= '0;
            end
        end else begin
            vld_p1 <= bus.snap_req;
            if (bus.snap_req) begin
                for (int i = 0; i < NUM_CNT; i++) begin
                    shadow_p1[i] <= live_p0[i];
                end
            end
        end
    end

    // Shadow select; unbuilt or unmapped indices fall through to 0
    always_comb begin
        rd_mux_p1 = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (bus.rd_sel == RD_SEL_W'(i)) rd_mux_p1 = shadow_p1[i];
        end
    end

    // ---- stage p2: registered read data ----
    always_ff @(posedge clk156) begin
        if (reset) begin
            rd_data_p2 <= '0;
        end else begin
            rd_data_p2 <= rd_mux_p1;
        end
    end

    assign bus.snap_done = vld_p1;
    assign bus.rd_data   = rd_data_p2;

endmodule

// File: tb/tb_mac_rx_stats_mon.sv
// tb_mac_rx_stats_mon: four monitor instances with different parameter sets
// share one stimulus stream; a behavioural model predicts every output.
module tb_mac_rx_stats_mon;

    localparam int ND = 4;
`ifdef MAC_RX_STATS_LEN_HIST_EN
    localparam bit HIST = 1'b1;
`else
    localparam bit HIST = 1'b0;
`endif
    localparam int NCNT = HIST ? 11 : 4;

    logic        clk;
    logic        rst;
    logic        mon_en, good, bad, sv_valid, snap;
    logic [28:0] sv_vec;
    logic [3:0]  sel;
    bit          chk_en;
    int          n_checks;
    int          n_fail;

    // Instance parameters: A 32/sat, B 16/sat, C 16/wrap, D 32/sat/clear-on-snap
    int unsigned cw    [ND] = '{32, 16, 16, 32};
    bit          sat_p [ND] = '{1'b1, 1'b1, 1'b0, 1'b1};
    bit          clr_p [ND] = '{1'b0, 1'b0, 1'b0, 1'b1};

    longint live     [ND][11];
    longint shad     [ND][11];
    longint rd_exp   [ND];
    bit     done_exp [ND];

    mac_rx_stats_mon_if #(.CNT_W(32)) if_a ();
    mac_rx_stats_mon_if #(.CNT_W(16)) if_b ();
    mac_rx_stats_mon_if #(.CNT_W(16)) if_c ();
    mac_rx_stats_mon_if #(.CNT_W(32)) if_d ();

    assign if_a.mon_en = mon_en; assign if_a.rx_good_frame = good; assign if_a.rx_bad_frame = bad;
    assign if_a.rx_statistics_vector = sv_vec; assign if_a.rx_statistics_valid = sv_valid;
    assign if_a.snap_req = snap; assign if_a.rd_sel = sel;
    assign if_b.mon_en = mon_en; assign if_b.rx_good_frame = good; assign if_b.rx_bad_frame = bad;
    assign if_b.rx_statistics_vector = sv_vec; assign if_b.rx_statistics_valid = sv_valid;
    assign if_b.snap_req = snap; assign if_b.rd_sel = sel;
    assign if_c.mon_en = mon_en; assign if_c.rx_good_frame = good; assign if_c.rx_bad_frame = bad;
    assign if_c.rx_statistics_vector = sv_vec; assign if_c.rx_statistics_valid = sv_valid;
    assign if_c.snap_req = snap; assign if_c.rd_sel = sel;
    assign if_d.mon_en = mon_en; assign if_d.rx_good_frame = good; assign if_d.rx_bad_frame = bad;
    assign if_d.rx_statistics_vector = sv_vec; assign if_d.rx_statistics_valid = sv_valid;
    assign if_d.snap_req = snap; assign if_d.rd_sel = sel;

    mac_rx_stats_mon #(.CNT_W(32), .SATURATE(1), .CLR_ON_SNAP(0))
        u_a (.clk156(clk), .reset(rst), .bus(if_a));
    mac_rx_stats_mon #(.CNT_W(16), .SATURATE(1), .CLR_ON_SNAP(0))
        u_b (.clk156(clk), .reset(rst), .bus(if_b));
    mac_rx_stats_mon #(.CNT_W(16), .SATURATE(0), .CLR_ON_SNAP(0))
        u_c (.clk156(clk), .reset(rst), .bus(if_c));
    mac_rx_stats_mon #(.CNT_W(32), .SATURATE(1), .CLR_ON_SNAP(1))
        u_d (.clk156(clk), .reset(rst), .bus(if_d));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counter arithmetic of width cw[k]: clamp or wrap past 2^W-1
    function automatic longint bump(input int k, input longint a, input longint b);
        longint lim;
        longint s;
        lim = (longint'(1) << cw[k]) - 1;
        s = a + b;
        if (s <= lim) return s;
        return sat_p[k] ? lim : (s - lim - 1);
    endfunction

    function automatic int bin_of(input longint len);
        if (len <= 64)   return 4;
        if (len <= 127)  return 5;
        if (len <= 255)  return 6;
        if (len <= 511)  return 7;
        if (len <= 1023) return 8;
        if (len <= 1518) return 9;
        return 10;
    endfunction

    task automatic cmp(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: evaluates the monitor rules once per rising edge
    always @(posedge clk) begin
        for (int k = 0; k < ND; k++) begin
            if (rst) begin
                for (int i = 0; i < 11; i++) begin
                    live[k][i] = 0;
                    shad[k][i] = 0;
                end
                rd_exp[k]   = 0;
                done_exp[k] = 1'b0;
            end else begin
                rd_exp[k]   = (int'(sel) < NCNT) ? shad[k][int'(sel)] : 0;
                done_exp[k] = snap;
                if (snap) begin
                    for (int i = 0; i < 11; i++) begin
                        shad[k][i] = live[k][i];
                        if (clr_p[k]) live[k][i] = 0;
                    end
                end
                if (mon_en) begin
                    if (good)     live[k][0] = bump(k, live[k][0], 1);
                    if (bad)      live[k][1] = bump(k, live[k][1], 1);
                    if (sv_valid) live[k][2] = bump(k, live[k][2], 1);
                    if (sv_valid && sv_vec[0]) begin
                        live[k][3] = bump(k, live[k][3], longint'(sv_vec[18:5]));
                        if (HIST) live[k][bin_of(longint'(sv_vec[18:5]))] =
                            bump(k, live[k][bin_of(longint'(sv_vec[18:5]))], 1);
                    end
                end
            end
        end
    end

    // Every-cycle comparison of all instance outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("rd_data_a",   longint'(if_a.rd_data),   rd_exp[0]);
            cmp("rd_data_b",   longint'(if_b.rd_data),   rd_exp[1]);
            cmp("rd_data_c",   longint'(if_c.rd_data),   rd_exp[2]);
            cmp("rd_data_d",   longint'(if_d.rd_data),   rd_exp[3]);
            cmp("snap_done_a", longint'(if_a.snap_done), longint'(done_exp[0]));
            cmp("snap_done_b", longint'(if_b.snap_done), longint'(done_exp[1]));
            cmp("snap_done_c", longint'(if_c.snap_done), longint'(done_exp[2]));
            cmp("snap_done_d", longint'(if_d.snap_done), longint'(done_exp[3]));
        end
    end

    task automatic drive(input bit g, input bit b, input bit v, input int len,
                         input bit ok, input bit s);
        @(negedge clk);
        good     = g;
        bad      = b;
        sv_valid = v;
        sv_vec   = v ? ((29'(len) << 5) | 29'(ok)) : '0;
        snap     = s;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic do_snap();
        drive(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        idle();
    endtask

    task automatic rd(input int s, output longint va, output longint vb,
                      output longint vc, output longint vd);
        @(negedge clk);
        sel = 4'(s);
        @(negedge clk);
        va = longint'(if_a.rd_data);
        vb = longint'(if_b.rd_data);
        vc = longint'(if_c.rd_data);
        vd = longint'(if_d.rd_data);
    endtask

    task automatic sweep();
        for (int s = 0; s < 16; s++) begin
            @(negedge clk);
            sel = 4'(s);
        end
        @(negedge clk);
    endtask

    longint va, vb, vc, vd;
    longint hexp;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        chk_en   = 1'b0;
        rst      = 1'b1;
        mon_en   = 1'b0;
        good     = 1'b0;
        bad      = 1'b0;
        sv_valid = 1'b0;
        sv_vec   = '0;
        snap     = 1'b0;
        sel      = '0;
        hexp     = HIST ? 1 : 0;

        @(negedge clk);
        chk_en = 1'b1;
        // Events and snap_req coincident with reset
        mon_en = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1518, 1'b1, 1'b1);
        idle();
        rst = 1'b0;
        cmp("reset_snap_done", longint'(if_a.snap_done), 0);
        rd(0, va, vb, vc, vd);
        cmp("reset_rd0_a", va, 0);
        sweep();

        // 5 good, 2 bad, two of them coincident
        drive(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        do_snap();
        cmp("snap_done_high", longint'(if_a.snap_done), 1);
        @(negedge clk);
        cmp("snap_done_one_cycle", longint'(if_a.snap_done), 0);
        rd(0, va, vb, vc, vd);
        cmp("good_cnt_a", va, 5);
        cmp("good_cnt_b", vb, 5);
        rd(1, va, vb, vc, vd);
        cmp("bad_cnt_a", va, 2);

        // Stats events: three good lengths and one bad-frame vector
        drive(1'b0, 1'b0, 1'b1, 64,   1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1518, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 9000, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 100,  1'b0, 1'b0);
        do_snap();
        rd(3, va, vb, vc, vd);
        cmp("bytes_a", va, 10582);
        rd(2, va, vb, vc, vd);
        cmp("stats_cnt_a", va, 4);
        rd(4, va, vb, vc, vd);
        cmp("bin4_a", va, hexp);
        rd(9, va, vb, vc, vd);
        cmp("bin9_a", va, hexp);
        rd(10, va, vb, vc, vd);
        cmp("bin10_a", va, hexp);
        rd(5, va, vb, vc, vd);
        cmp("bin5_a", va, 0);
        sweep();

        // Clear-on-snap with a coincident good pulse
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        idle();
        rd(0, va, vb, vc, vd);
        cmp("clr_snap_d", vd, 7);
        cmp("noclr_snap_a", va, 12);
        do_snap();
        rd(0, va, vb, vc, vd);
        cmp("clr_next_snap_d", vd, 1);
        cmp("noclr_next_snap_a", va, 13);

        // Back-to-back snapshots
        drive(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        cmp("b2b_done_1", longint'(if_a.snap_done), 1);
        idle();
        cmp("b2b_done_2", longint'(if_a.snap_done), 1);
        @(negedge clk);
        cmp("b2b_done_end", longint'(if_a.snap_done), 0);
        rd(0, va, vb, vc, vd);
        cmp("b2b_a", va, 14);
        cmp("b2b_d", vd, 1);

        // Counting disabled; snapshot and read still work
        mon_en = 1'b0;
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        do_snap();
        mon_en = 1'b1;
        rd(0, va, vb, vc, vd);
        cmp("mon_off_a", va, 14);
        rd(15, va, vb, vc, vd);
        cmp("sel15_a", va, 0);
        cmp("sel15_b", vb, 0);
        cmp("sel15_d", vd, 0);

        // Saturate versus wrap at 16 bits
        @(negedge clk);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        for (int i = 0; i < 70000; i++) drive(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        do_snap();
        rd(0, va, vb, vc, vd);
        cmp("sat16_b", vb, 65535);
        cmp("wrap16_c", vc, 4464);
        cmp("w32_a", va, 70000);
        sweep();

        // Reset coincident with events and snap_req
        @(negedge clk);
        rst      = 1'b1;
        good     = 1'b1;
        bad      = 1'b1;
        sv_valid = 1'b1;
        sv_vec   = (29'(300) << 5) | 29'(1);
        snap     = 1'b1;
        idle();
        rst = 1'b0;
        cmp("rst_override_done", longint'(if_a.snap_done), 0);
        rd(0, va, vb, vc, vd);
        cmp("rst_override_a", va, 0);
        cmp("rst_override_c", vc, 0);
        sweep();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_rx_stats_mon.md
MAC_RX_STATS_MON -- requirements
Module: mac_rx_stats_mon

Interface
REQ-001 Parameter CNT_W, default 32: width of every statistics counter, legal range 16..48.
REQ-002 Parameter SATURATE, default 1: 1 = counters stick at all-ones; 0 = counters wrap modulo 2^CNT_W.
REQ-003 Parameter CLR_ON_SNAP, default 0: 1 = live counters clear when a snapshot is taken.
REQ-004 clk156  in  1  single 156.25 MHz XGMII/MAC RX clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 mon_en  in  1  1 = counting enabled; 0 = live counters hold.
REQ-007 rx_good_frame  in  1  MAC good-frame pulse.
REQ-008 rx_bad_frame  in  1  MAC bad-frame pulse.
REQ-009 rx_statistics_vector  in  29  MAC RX statistics vector; bit 0 = frame OK, bits [18:5] = frame length in bytes.
REQ-010 rx_statistics_valid  in  1  qualifies rx_statistics_vector for one cycle.
REQ-011 snap_req  in  1  single-cycle request to copy all live counters to shadow registers.
REQ-012 snap_done  out  1  one-cycle pulse; shadow registers updated.
REQ-013 rd_sel  in  4  shadow counter index.
REQ-014 rd_data  out  CNT_W  selected shadow counter, registered.

Function
REQ-015 Counter map: 0 good frames, 1 bad frames, 2 stats-valid events, 3 good bytes; 4..10 length bins (histogram build only).
REQ-016 With mon_en=1: counter 0 increments on rx_good_frame, counter 1 on rx_bad_frame, counter 2 on rx_statistics_valid.
REQ-017 Counter 3 adds the zero-extended bits [18:5] when rx_statistics_valid=1 and bit 0=1.
REQ-018 Good and bad pulses in the same cycle increment both counters.
REQ-019 SATURATE=1: any increment or addition whose true result exceeds 2^CNT_W-1 leaves the counter at 2^CNT_W-1.
REQ-020 SATURATE=0: all counters wrap; all-ones+1 = 0.
REQ-021 snap_req at cycle N: shadows hold the live values before any cycle-N increment; snap_done=1 in cycle N+1.
REQ-022 CLR_ON_SNAP=1: a live counter with a cycle-N event becomes that event's increment, not 0; otherwise it becomes 0.
REQ-023 snap_req is ignored while reset=1; back-to-back snap_req pulses are each honoured.
REQ-024 rd_data = shadow[rd_sel], registered, 1-cycle latency.
REQ-025 rd_sel unmapped or unbuilt (11..15; 4..10 without histogram) returns 0.
REQ-026 mon_en=0 blocks counting only; snapshots and reads still operate.

Reset
REQ-027 reset=1 clears all live counters, all shadow registers, rd_data and snap_done to 0 on the next clk156 edge.
REQ-028 reset overrides any coincident event or snap_req; no partial update is permitted.

Configuration
REQ-029 Macro MAC_RX_STATS_LEN_HIST_EN defined: builds counters 4..10.
REQ-030 Histogram counters are updated only on qualified good stats events (rx_statistics_valid=1 and bit 0=1), using the frame length in bits [18:5].
REQ-031 Histogram bins: 4 = <=64, 5 = 65-127, 6 = 128-255, 7 = 256-511, 8 = 512-1023, 9 = 1024-1518, 10 = >1518.
REQ-032 Histogram counters follow the same SATURATE and snapshot rules as counters 0..3.
REQ-033 Macro undefined: no histogram logic is built and rd_sel 4..10 returns 0.

Structure
REQ-034 Shared package mac_mon_pkg holds the counter index constants, length-bin boundaries, and the statistics-vector bit positions (OK bit 0, length [18:5]).
REQ-035 One sub-module, mac_stat_cnt, implements one counter (increment amount, enable, SATURATE, clear-with-add); it is instantiated per counter.

Verification
REQ-036 Reset, then 5 rx_good_frame pulses and 2 rx_bad_frame pulses, 2 of them coincident, then snap_req -> shadows 0/1 read 5/2; snap_done is high exactly 1 cycle.
REQ-037 CNT_W=16, SATURATE=1, 70000 good pulses, then snap -> counter 0 reads 0xFFFF; with SATURATE=0 -> reads 70000 mod 65536 = 4464.
REQ-038 Good stats events with lengths 64, 1518 and 9000 -> counter 3 reads 10582; with the histogram build, bins 4/9/10 read 1/1/1.
REQ-039 CLR_ON_SNAP=1, counter 0 at 7, snap_req coincident with a good pulse -> shadow 0 reads 7; the next snap reads 1.
REQ-040 mon_en=0 with 10 good pulses, then snap -> counter 0 unchanged; rd_sel=15 -> rd_data 0.
REQ-041 reset asserted with snap_req and event pulses in the same cycle -> all reads 0, no snap_done.
